// File: rtl/binary_to_rns.sv
// binary_to_rns: bit-serial forward converter from a 9-bit unsigned binary
// operand to a 3-channel residue number system representation.
//
// Conversion runs MSB first. Each step computes r = (2r + b) mod m with a
// single conditional subtract. This step is exact as long as r < m holds
// before the step. A channel whose modulus is 0 or 1 is forced to residue 0.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid / in_ready - operand handshake (ready only while idle)
//   bin_in              - 9-bit unsigned operand
//   moduli1..3          - 3-bit modulus per channel
//   out_valid/out_ready - result handshake (valid only when done)
//   res1..res3          - residues, held while out_valid && !out_ready
//   err                 - only with FWD_CONV_ERR_EN defined; set when any
//                         modulus < 2 at accept, cleared on return to idle
//
// Optional feature macro: FWD_CONV_ERR_EN
module binary_to_rns (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] bin_in,
  input  logic [2:0] moduli1,
  input  logic [2:0] moduli2,
  input  logic [2:0] moduli3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] res1,
  output logic [2:0] res2,
  output logic [2:0] res3
`ifdef FWD_CONV_ERR_EN
  ,
  output logic       err
`endif
);

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                        state_q, state_d;
  logic [8:0]                    bin_q, bin_d;
  logic [NUM_CH-1:0][2:0]        mod_q, mod_d;
  logic [NUM_CH-1:0][2:0]        res_q, res_d;
  logic [3:0]                    cnt_q, cnt_d;
  // Set once bit 0 has been folded in; the following edge moves to DONE.
  logic                          last_q, last_d;
`ifdef FWD_CONV_ERR_EN
  logic                          err_q, err_d;
`endif

  // One residue step. r < m on entry, so t = 2r+b < 2m. A single subtract
  // therefore brings t back below m, and the result fits in 3 bits.
  function automatic logic [2:0] rns_step(input logic [2:0] r,
                                          input logic       b,
                                          input logic [2:0] m);
    logic [3:0] t;
    logic [3:0] diff;
    t    = {r, b};
    diff = t - {1'b0, m};
    if (m < 3'd2)            rns_step = 3'd0;
    else if (t >= {1'b0, m}) rns_step = diff[2:0];
    else                     rns_step = t[2:0];
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    mod_d   = mod_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef FWD_CONV_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = bin_in;
          mod_d   = {moduli3, moduli2, moduli1};
          res_d   = '0;
          cnt_d   = 4'd8;
          last_d  = 1'b0;
`ifdef FWD_CONV_ERR_EN
          err_d   = (moduli1 < 3'd2) || (moduli2 < 3'd2) || (moduli3 < 3'd2);
`endif
          state_d = CONV;
        end
      end
      CONV: begin
        if (last_q) begin
          state_d = DONE;
        end else begin
          for (int ch = 0; ch < NUM_CH; ch++)
            res_d[ch] = rns_step(res_q[ch], bin_q[cnt_q], mod_q[ch]);
          if (cnt_q == 4'd0) last_d = 1'b1;
          else               cnt_d  = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef FWD_CONV_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      mod_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
`ifdef FWD_CONV_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      mod_q   <= mod_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef FWD_CONV_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res1      = res_q[0];
  assign res2      = res_q[1];
  assign res3      = res_q[2];
`ifdef FWD_CONV_ERR_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_binary_to_rns.sv
// Self-checking bench for binary_to_rns. A scoreboard queue receives the
// expected residues at each accept. A negedge monitor pops and compares the
// queue on every result handshake.
module tb_binary_to_rns;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] bin_in;
  logic [2:0] moduli1, moduli2, moduli3;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] res1, res2, res3;
`ifdef FWD_CONV_ERR_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  binary_to_rns dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .moduli1   (moduli1),
    .moduli2   (moduli2),
    .moduli3   (moduli3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res1      (res1),
    .res2      (res2),
    .res3      (res3)
`ifdef FWD_CONV_ERR_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    int r1;
    int r2;
    int r3;
    int e;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_mod(input int b, input int m);
    return (m < 2) ? 0 : (b % m);
  endfunction

  task automatic push_exp(input int b, input int m1, input int m2, input int m3);
    exp_t x;
    x.r1 = ref_mod(b, m1);
    x.r2 = ref_mod(b, m2);
    x.r3 = ref_mod(b, m3);
    x.e  = (m1 < 2 || m2 < 2 || m3 < 2) ? 1 : 0;
    sb.push_back(x);
  endtask

  // Result monitor: compares every handshake against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_pop", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        chk("res1", int'(res1), x.r1);
        chk("res2", int'(res2), x.r2);
        chk("res3", int'(res3), x.r3);
`ifdef FWD_CONV_ERR_EN
        chk("err", int'(err), x.e);
`endif
      end
    end
  end

  // All procedures below are entered and left at #1 after a rising edge.
  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rdy_wait", int'(in_ready), 1);
  endtask

  // Returns the number of edges until out_valid is seen (31 on timeout).
  task automatic wait_out(output int k);
    k = 0;
    while (k <= 30) begin
      @(posedge clk); #1;
      k++;
      if (out_valid) break;
    end
    if (!out_valid) k = 31;
  endtask

  // Drive one operand for a single accept edge, then scramble the inputs.
  task automatic accept(input int b, input int m1, input int m2, input int m3);
    wait_ready();
    in_valid = 1'b1;
    bin_in   = 9'(b);
    moduli1  = 3'(m1);
    moduli2  = 3'(m2);
    moduli3  = 3'(m3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in   = 9'($urandom);
    moduli1  = 3'($urandom);
    moduli2  = 3'($urandom);
    moduli3  = 3'($urandom);
    chk("busy_after_acc", int'(in_ready), 0);
  endtask

  task automatic run_op(input string tag, input int b, input int m1,
                        input int m2, input int m3);
    int lat;
    push_exp(b, m1, m2, m3);
    accept(b, m1, m2, m3);
    wait_out(lat);
    chk({tag, "_lat"}, lat, 10);
    @(posedge clk); #1;
    chk({tag, "_idle"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bin_in    = '0;
    moduli1   = '0;
    moduli2   = '0;
    moduli3   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_res", int'({res1, res2, res3}), 0);
`ifdef FWD_CONV_ERR_EN
    chk("rst_err", int'(err), 0);
`endif
    rst = 1'b0;

    run_op("basic", 100, 5, 6, 7);
    run_op("max", 511, 7, 6, 5);

    // Backpressure: results hold, stray in_valid is ignored.
    push_exp(200, 7, 6, 5);
    out_ready = 1'b0;
    accept(200, 7, 6, 5);
    wait_out(lat);
    chk("bp_lat", lat, 10);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_hold", int'({res1, res2, res3}), int'({3'd4, 3'd2, 3'd0}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", int'(in_ready), 1);
    chk("bp_drop", int'(out_valid), 0);

    // Reset four edges after accept discards the operand.
    accept(300, 5, 6, 7);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_in_ready", int'(in_ready), 1);
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_res", int'({res1, res2, res3}), 0);
    run_op("post_rst", 13, 5, 6, 7);

    // Degenerate moduli.
    run_op("degen", 77, 0, 1, 4);
`ifdef FWD_CONV_ERR_EN
    chk("err_clr", int'(err), 0);
`endif

    // Back-to-back with in_valid held high.
    push_exp(50, 3, 4, 5);
    push_exp(37, 7, 5, 3);
    wait_ready();
    in_valid = 1'b1;
    bin_in = 9'd50; moduli1 = 3'd3; moduli2 = 3'd4; moduli3 = 3'd5;
    @(posedge clk); #1;
    bin_in = 9'd37; moduli1 = 3'd7; moduli2 = 3'd5; moduli3 = 3'd3;
    wait_out(lat);
    chk("b2b_lat1", lat, 10);
    @(posedge clk); #1;
    chk("b2b_no_same_edge", int'(in_ready), 1);
    @(posedge clk); #1;
    chk("b2b_accept2", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("b2b_lat2", lat, 10);
    @(posedge clk); #1;

    // Random operands against the arithmetic model.
    for (int i = 0; i < 8; i++)
      run_op("rand", int'($urandom_range(511)), int'($urandom_range(7)),
             int'($urandom_range(7)), int'($urandom_range(7)));

    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
